// File: rtl/rect_fill_engine_if.sv
// +----------------------------------------------------------------------------+
// | Module   : rect_fill_engine_if                                             |
// | Purpose  : Command and pixel-stream bundle between the game datapath,      |
// |            rect_fill_engine and vga_adapter.                               |
// | Signals  : req_valid/req_ready handshake with req_x, req_y, req_w, req_h,  |
// |            req_colour (command). x, y, colour, plot (pixel stream). busy,  |
// |            done (status).                                                  |
// | Modports : master = command issuer / pixel consumer, slave = the engine.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface rect_fill_engine_if #(
   parameter int W_BITS = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [7:0]        req_x;
   logic [6:0]        req_y;
   logic [W_BITS-1:0] req_w;
   logic [W_BITS-1:0] req_h;
   logic [2:0]        req_colour;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [2:0]        colour;
   logic              plot;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_x, req_y, req_w, req_h, req_colour,
      input  req_ready, x, y, colour, plot, busy, done
   );

   modport slave (
      input  req_valid, req_x, req_y, req_w, req_h, req_colour,
      output req_ready, x, y, colour, plot, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/rect_fill_engine.sv
// +----------------------------------------------------------------------------+
// | Module   : rect_fill_engine                                                |
// | Purpose  : Accepts one rectangle command (origin, size, colour) and emits  |
// |            it as a row-major pixel stream, one pixel per clock, followed   |
// |            by a one-cycle done pulse.                                      |
// | Ports    : clock  - system clock                                           |
// |            resetn - asynchronous active-low reset                          |
// |            bus    - rect_fill_engine_if.slave (command handshake, pixel    |
// |                     stream x/y/colour/plot, busy, done)                    |
// | Params   : W_BITS   - width of the size fields                             |
// |            SCREEN_W - horizontal resolution (clipping)                     |
// |            SCREEN_H - vertical resolution (clipping)                       |
// | Options  : RECT_CLIP_EN - when defined, plot is suppressed for pixels that |
// |            fall outside SCREEN_W x SCREEN_H; timing is unchanged.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rect_fill_engine #(
   parameter int W_BITS   = 5,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  wire logic          clock,
   input  wire logic          resetn,
   rect_fill_engine_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [8:0] c_screen_w = 9'(SCREEN_W);
   localparam logic [7:0] c_screen_h = 8'(SCREEN_H);

`ifdef RECT_CLIP_EN
   localparam logic c_clip_en = 1'b1;
`else
   localparam logic c_clip_en = 1'b0;
`endif

   state_t            r_state;
   logic [7:0]        r_x0;
   logic [6:0]        r_y0;
   logic [W_BITS-1:0] r_w;
   logic [W_BITS-1:0] r_h;
   logic [2:0]        r_colour;
   logic [W_BITS-1:0] r_cx;
   logic [W_BITS-1:0] r_cy;

   logic [8:0]        w_sum_x;
   logic [7:0]        w_sum_y;
   logic              w_cx_last;
   logic              w_cy_last;
   logic              w_on_screen;
   logic              w_draw;

   // Sums are one bit wider than the outputs so clipping sees the true
   // coordinate before truncation.
   assign w_sum_x     = {1'b0, r_x0} + 9'(r_cx);
   assign w_sum_y     = {1'b0, r_y0} + 8'(r_cy);
   assign w_cx_last   = (r_cx == r_w - W_BITS'(1));
   assign w_cy_last   = (r_cy == r_h - W_BITS'(1));
   assign w_on_screen = (w_sum_x < c_screen_w) && (w_sum_y < c_screen_h);
   assign w_draw      = (r_state == S_DRAW);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_x0     <= '0;
         r_y0     <= '0;
         r_w      <= '0;
         r_h      <= '0;
         r_colour <= '0;
         r_cx     <= '0;
         r_cy     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // req_ready is high throughout IDLE, so valid alone accepts.
               if (bus.req_valid) begin
                  r_x0     <= bus.req_x;
                  r_y0     <= bus.req_y;
                  r_w      <= bus.req_w;
                  r_h      <= bus.req_h;
                  r_colour <= bus.req_colour;
                  r_cx     <= '0;
                  r_cy     <= '0;
                  if ((bus.req_w != '0) && (bus.req_h != '0)) begin
                     r_state <= S_DRAW;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DRAW: begin
               if (w_cx_last) begin
                  r_cx <= '0;
                  r_cy <= r_cy + 1'b1;
                  if (w_cy_last) begin
                     r_state <= S_DONE;
                  end
               end else begin
                  r_cx <= r_cx + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Every output is a decode of registered state only; nothing from req_*
   // reaches the pixel stream combinationally.
   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.x         = w_sum_x[7:0];
   assign bus.y         = w_sum_y[6:0];
   assign bus.colour    = w_draw ? r_colour : 3'd0;
   assign bus.plot      = w_draw && (w_on_screen || !c_clip_en);

endmodule

`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_rect_fill_engine                                             |
// | Purpose  : Self-checking bench for rect_fill_engine. A queue-based model   |
// |            expands each accepted command into its expected per-cycle      |
// |            outputs; a compare process checks the DUT every cycle.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rect_fill_engine;

   localparam int W_BITS   = 5;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
`ifdef RECT_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   typedef struct {
      int x;
      int y;
      int colour;
      bit plot;
      bit busy;
      bit done;
      bit ready;
      bit chk_xy;
   } exp_t;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;
   exp_t exp_q[$];
   exp_t lst[$];
   bit   was_idle;

   rect_fill_engine_if #(.W_BITS(W_BITS)) bus();

   rect_fill_engine #(
      .W_BITS  (W_BITS),
      .SCREEN_W(SCREEN_W),
      .SCREEN_H(SCREEN_H)
   ) dut (
      .clock (clk),
      .resetn(resetn),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
      end
   endtask

   // Expected per-cycle outputs for one accepted command: w*h pixels in
   // row-major order, then the done cycle.
   function automatic void model_cmd(input int x0, input int y0, input int w,
                                     input int h, input int col, output exp_t q[$]);
      exp_t e;
      q.delete();
      if (w > 0 && h > 0) begin
         for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
               e.x      = (x0 + c) % 256;
               e.y      = (y0 + r) % 128;
               e.colour = col;
               e.plot   = CLIP ? ((x0 + c) < SCREEN_W && (y0 + r) < SCREEN_H) : 1'b1;
               e.busy   = 1'b1;
               e.done   = 1'b0;
               e.ready  = 1'b0;
               e.chk_xy = 1'b1;
               q.push_back(e);
            end
         end
      end
      e.x = 0; e.y = 0; e.colour = 0; e.plot = 1'b0;
      e.busy = 1'b1; e.done = 1'b1; e.ready = 1'b0; e.chk_xy = 1'b0;
      q.push_back(e);
   endfunction

   // Model update on the edge, compare on the falling edge.
   initial begin
      exp_t e;
      exp_t m[$];
      was_idle = 1'b1;
      forever begin
         @(posedge clk);
         if (!resetn) begin
            exp_q.delete();
         end else if (was_idle && bus.req_valid) begin
            model_cmd(int'(bus.req_x), int'(bus.req_y), int'(bus.req_w),
                      int'(bus.req_h), int'(bus.req_colour), m);
            foreach (m[i]) exp_q.push_back(m[i]);
         end
         @(negedge clk);
         if (!resetn) begin
            e.x = 0; e.y = 0; e.colour = 0; e.plot = 0; e.busy = 0;
            e.done = 0; e.ready = 1; e.chk_xy = 1;
            was_idle = 1'b1;
         end else if (exp_q.size() == 0) begin
            e.x = 0; e.y = 0; e.colour = 0; e.plot = 0; e.busy = 0;
            e.done = 0; e.ready = 1; e.chk_xy = 0;
            was_idle = 1'b1;
         end else begin
            e = exp_q.pop_front();
            was_idle = 1'b0;
         end
         chk("plot",   32'(bus.plot),      32'(e.plot));
         chk("busy",   32'(bus.busy),      32'(e.busy));
         chk("done",   32'(bus.done),      32'(e.done));
         chk("ready",  32'(bus.req_ready), 32'(e.ready));
         chk("colour", 32'(bus.colour),    32'(e.colour));
         if (e.chk_xy) begin
            chk("x", 32'(bus.x), 32'(e.x));
            chk("y", 32'(bus.y), 32'(e.y));
         end
      end
   end

   // Called right after a falling edge; returns on the falling edge after
   // acceptance with req_valid dropped.
   task automatic send(input int x0, input int y0, input int w, input int h, input int col);
      int n;
      bus.req_x      = 8'(x0);
      bus.req_y      = 7'(y0);
      bus.req_w      = W_BITS'(w);
      bus.req_h      = W_BITS'(h);
      bus.req_colour = 3'(col);
      bus.req_valid  = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         failures++;
         $display("FAIL send_timeout actual=%0d expected=<2000", n);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d expected=<3000", n);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int plots;
      checks = 0;
      failures = 0;
      resetn = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
      bus.req_colour = '0;

      // Hand-computed expectations that pin the model.
      model_cmd(10, 20, 3, 2, 4, lst);
      chk("pin_basic_len", 32'(lst.size()), 32'd7);
      chk("pin_basic_p0x", 32'(lst[0].x), 32'd10);
      chk("pin_basic_p0y", 32'(lst[0].y), 32'd20);
      chk("pin_basic_p3x", 32'(lst[3].x), 32'd10);
      chk("pin_basic_p3y", 32'(lst[3].y), 32'd21);
      chk("pin_basic_p5x", 32'(lst[5].x), 32'd12);
      chk("pin_basic_done", 32'(lst[6].done), 32'd1);
      model_cmd(0, 5, 0, 5, 2, lst);
      chk("pin_zero_len", 32'(lst.size()), 32'd1);
      model_cmd(158, 118, 4, 4, 1, lst);
      plots = 0;
      foreach (lst[i]) plots += int'(lst[i].plot);
      chk("pin_clip_plots", 32'(plots), CLIP ? 32'd4 : 32'd16);
      chk("pin_clip_x160", 32'(lst[2].x), 32'd160);
      chk("pin_clip_y121", 32'(lst[15].y), 32'd121);
      model_cmd(0, 0, 31, 31, 7, lst);
      chk("pin_max_len", 32'(lst.size()), 32'd962);
      chk("pin_max_lastx", 32'(lst[960].x), 32'd30);
      chk("pin_max_lasty", 32'(lst[960].y), 32'd30);

      repeat (3) @(negedge clk);
      chk("reset_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_plot",  32'(bus.plot), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Basic fill, zero size, clipping corner.
      send(10, 20, 3, 2, 4);
      drain();
      send(7, 9, 0, 5, 3);
      drain();
      send(158, 118, 4, 4, 5);
      drain();

      // Command held while busy, then changed to B mid-draw.
      send(30, 40, 2, 2, 1);
      bus.req_x = 8'd50; bus.req_y = 7'd60; bus.req_w = 5'd1; bus.req_h = 5'd1;
      bus.req_colour = 3'd6; bus.req_valid = 1'b1;
      n = 0;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", 32'(bus.done), 32'd1);
      @(negedge clk);
      chk("b2b_gap_plot",  32'(bus.plot), 32'd0);
      chk("b2b_gap_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      chk("b2b_b_plot",   32'(bus.plot), 32'd1);
      chk("b2b_b_colour", 32'(bus.colour), 32'd6);
      bus.req_valid = 1'b0;
      drain();

      // Reset asserted during pixel 5 of a 31x31 draw.
      send(3, 4, 31, 31, 5);
      repeat (4) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("rst_async_plot", 32'(bus.plot), 32'd0);
      chk("rst_async_busy", 32'(bus.busy), 32'd0);
      chk("rst_async_x",    32'(bus.x), 32'd0);
      chk("rst_async_y",    32'(bus.y), 32'd0);
      chk("rst_async_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      repeat (3) @(negedge clk);
      send(0, 0, 2, 2, 6);
      drain();

      // Maximum size.
      send(0, 0, 31, 31, 7);
      drain();

      // Randomized commands, including back-to-back and off-screen origins.
      for (int k = 0; k < 40; k++) begin
         int rx, ry, rw, rh, gap;
         rx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
         ry  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 119));
         rw  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
         rh  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
         if ($urandom_range(0, 9) == 0) rw = 31;
         gap = int'($urandom_range(0, 3));
         send(rx, ry, rw, rh, int'($urandom_range(0, 7)));
         repeat (gap) @(negedge clk);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
